// File: rtl/snoop_controller.sv
// Snoopy MSI coherence controller: three processors with one-line caches
// sharing a four-word memory. One request is serviced at a time through a
// fixed sequence of bus phases; outputs describe the last completed request.
module snoop_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [9:0] entrada,
  output logic       ready,
  output logic       inst,
  output logic [1:0] processador,
  output logic [2:0] signal,
  output logic [2:0] signal2,
  output logic [2:0] stateOri,
  output logic [2:0] stateDest,
  output logic [8:0] cacheP1,
  output logic [8:0] cacheP2,
  output logic [8:0] cacheP3,
  output logic [3:0] memoria,
  output logic [3:0] data,
  output logic       achei
);

  localparam logic [2:0] ST_I = 3'b000, ST_S = 3'b001, ST_M = 3'b010;
  localparam logic [2:0] MSG_NONE = 3'b000, MSG_RMISS = 3'b001,
                         MSG_WMISS = 3'b010, MSG_INVAL = 3'b011;
  localparam logic [2:0] RSP_NONE = 3'b000, RSP_WB = 3'b001,
                         RSP_SHARED = 3'b010, RSP_ACK = 3'b011;

  typedef enum logic [2:0] {IDLE, LOOKUP, BUS, SNOOP, WB, UPDATE, DONE} fsm_t;
  fsm_t state, next;

  // Latched request
  logic [1:0] req_id, req_tag;
  logic       req_wr;
  logic [3:0] req_wdata;

  // Cache lines indexed by processor id, and main memory
  logic [2:0] cst  [1:3];
  logic [1:0] ctag [1:3];
  logic [3:0] cdat [1:3];
  logic [3:0] mem  [0:3];

  // Per-transaction bookkeeping
  logic       achei_r, victim_pend, remote_pend;
  logic [2:0] ori_r, sig_r, sig2_r;

  // Bit 6 of the request word carries nothing
  logic unused_bit;
  assign unused_bit = entrada[6];

  // Lookup and snoop decode against the latched request
  logic [2:0] own_st;
  logic       hit, any_m, any_s, victim_need;
  logic [1:0] m_idx;

  // Requester hit test and search of the remote caches for the request tag
  always_comb begin
    own_st      = cst[req_id];
    hit         = (own_st != ST_I) && (ctag[req_id] == req_tag);
    any_m       = 1'b0;
    any_s       = 1'b0;
    m_idx       = 2'd1;
    for (int j = 1; j <= 3; j++) begin
      if (2'(j) != req_id && ctag[j] == req_tag) begin
        if (cst[j] == ST_M) begin
          any_m = 1'b1;
          m_idx = 2'(j);
        end
        if (cst[j] == ST_S) any_s = 1'b1;
      end
    end
    victim_need = !hit && (own_st == ST_M);
  end

  assign ready   = (state == IDLE);
  assign inst    = (state == DONE);
  assign cacheP1 = {cst[1], ctag[1], cdat[1]};
  assign cacheP2 = {cst[2], ctag[2], cdat[2]};
  assign cacheP3 = {cst[3], ctag[3], cdat[3]};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (valid && entrada[9:8] != 2'd0) next = LOOKUP;
      LOOKUP:  next = (hit && (!req_wr || own_st == ST_M)) ? UPDATE : BUS;
      BUS:     next = SNOOP;
      SNOOP:   next = (victim_need || any_m) ? WB : UPDATE;
      WB:      next = (victim_pend && remote_pend) ? WB : UPDATE;
      UPDATE:  next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Request capture, coherence actions on caches/memory, and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_id <= '0; req_tag <= '0; req_wr <= 1'b0; req_wdata <= '0;
      for (int j = 1; j <= 3; j++) begin
        cst[j] <= ST_I; ctag[j] <= '0; cdat[j] <= '0;
      end
      for (int i = 0; i < 4; i++) mem[i] <= 4'(i + 1);
      achei_r <= 1'b0; victim_pend <= 1'b0; remote_pend <= 1'b0;
      ori_r <= '0; sig_r <= '0; sig2_r <= '0;
      processador <= '0; signal <= '0; signal2 <= '0; stateOri <= '0;
      stateDest <= '0; memoria <= '0; data <= '0; achei <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          req_id    <= entrada[9:8];
          req_wr    <= entrada[7];
          req_tag   <= entrada[5:4];
          req_wdata <= entrada[3:0];
        end
        LOOKUP: begin
          achei_r <= hit;
          ori_r   <= own_st;
          sig2_r  <= RSP_NONE;
          if (hit && (!req_wr || own_st == ST_M)) sig_r <= MSG_NONE;
          else if (hit)                           sig_r <= MSG_INVAL;
          else                                    sig_r <= req_wr ? MSG_WMISS : MSG_RMISS;
        end
        SNOOP: begin
          victim_pend <= victim_need;
          remote_pend <= any_m;
          if (sig_r == MSG_RMISS)
            sig2_r <= any_m ? RSP_WB : (any_s ? RSP_SHARED : RSP_NONE);
          else if (sig_r == MSG_INVAL)
            sig2_r <= any_s ? RSP_ACK : RSP_NONE;
          else
            sig2_r <= any_m ? RSP_WB : RSP_NONE;
        end
        WB: begin
          // Evicted local dirty line goes out first, then the remote owner
          if (victim_pend) begin
            mem[ctag[req_id]] <= cdat[req_id];
            victim_pend       <= 1'b0;
          end else if (remote_pend) begin
            mem[req_tag] <= cdat[m_idx];
            remote_pend  <= 1'b0;
          end
        end
        UPDATE: begin
          // Remote copies of the tag: reads demote to S, writes invalidate
          if (sig_r != MSG_NONE) begin
            for (int j = 1; j <= 3; j++)
              if (2'(j) != req_id && ctag[j] == req_tag && cst[j] != ST_I)
                cst[j] <= req_wr ? ST_I : ST_S;
          end
          processador <= req_id;
          signal      <= sig_r;
          signal2     <= sig2_r;
          stateOri    <= ori_r;
          achei       <= achei_r;
          memoria     <= mem[req_tag];
          if (req_wr) begin
            cst[req_id]  <= ST_M;
            ctag[req_id] <= req_tag;
            cdat[req_id] <= req_wdata;
            stateDest    <= ST_M;
            data         <= req_wdata;
          end else if (achei_r) begin
            stateDest <= own_st;
            data      <= cdat[req_id];
          end else begin
            cst[req_id]  <= ST_S;
            ctag[req_id] <= req_tag;
            cdat[req_id] <= mem[req_tag];
            stateDest    <= ST_S;
            data         <= mem[req_tag];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/snoop_controller.md
SNOOP_CONTROLLER -- requirements
Module: snoop_controller

Interface
REQ-001 No parameters; 3 processors, 1-line caches, 4-word memory fixed.
REQ-002 clock  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 valid  in  1  request present on entrada.
REQ-005 entrada  in  10  [9:8] processor id (1..3), [7] op (0 read, 1 write), [6] unused, [5:4] address/tag, [3:0] write data.
REQ-006 ready  out  1  high only in IDLE; request accepted on edge with valid&ready.
REQ-007 inst  out  1  one-cycle pulse: transaction complete, observation outputs updated.
REQ-008 processador  out  2  id of the last completed requester.
REQ-009 signal  out  3  bus message issued by requester: 000 NONE, 001 READ_MISS, 010 WRITE_MISS, 011 INVALIDATE.
REQ-010 signal2  out  3  snoop response: 000 NONE, 001 WRITEBACK, 010 HIT_SHARED, 011 INVAL_ACK.
REQ-011 stateOri / stateDest  out  3 each  requester line state before / after: 000 I, 001 S, 010 M.
REQ-012 cacheP1, cacheP2, cacheP3  out  9 each  live line contents {state[8:6], tag[5:4], data[3:0]}.
REQ-013 memoria  out  4  memory word at the transaction address after completion.
REQ-014 data  out  4  word read (read op) or written (write op).
REQ-015 achei  out  1  requester hit (state S/M and tag match at LOOKUP).

Function
REQ-016 FSM states: IDLE, LOOKUP, BUS, SNOOP, WB, UPDATE, DONE; one cycle each except WB.
REQ-017 IDLE -> LOOKUP on accept; request fields latched; valid ignored outside IDLE.
REQ-018 Processor id 0: request consumed in IDLE, no state change, no inst pulse, stays IDLE.
REQ-019 LOOKUP -> UPDATE for read hit (S/M) or write hit in M; otherwise -> BUS.
REQ-020 BUS -> SNOOP; SNOOP compares remote caches with tag; -> WB if any writeback needed, else -> UPDATE.
REQ-021 WB: one cycle per writeback, at most two: first local victim (requester M, different tag) to memory[victim tag], then remote M holder to memory[tag]; -> UPDATE.
REQ-022 Read miss: signal READ_MISS; remote M match -> remote S, signal2 WRITEBACK; else any remote S match -> signal2 HIT_SHARED; else NONE; requester -> S with memory data.
REQ-023 Write hit in S: signal INVALIDATE; remote S matches -> I; signal2 INVAL_ACK if any invalidated else NONE; requester -> M with new data; memory unchanged.
REQ-024 Write miss: signal WRITE_MISS; remote M match written back then -> I, signal2 WRITEBACK; remote S matches -> I; requester -> M with new data.
REQ-025 Hits without bus: signal NONE, signal2 NONE, achei 1; write hit in M updates data only.
REQ-026 Cache lines and memory change only in WB/UPDATE; cacheP* reflect them immediately.
REQ-027 processador, signal, signal2, stateOri, stateDest, memoria, data, achei registered, updated at DONE entry, held until next DONE.
REQ-028 inst high exactly during the DONE cycle; DONE -> IDLE.
REQ-029 Latency accept-edge to inst-high: 3 cycles for no-bus hit, 5 for bus without writeback, +1 per writeback (max 7).
REQ-030 At most one remote M holder exists per tag; invariant preserved by protocol.

Reset
REQ-031 reset forces IDLE immediately, including mid-transaction; in-flight request discarded, no inst pulse.
REQ-032 Reset values: all cacheP* 9'b000_00_0000, memory[i]=i+1 (1,2,3,4), ready 1, inst 0, all other outputs 0.

Verification
REQ-033 Reset; P1 read tag 2 -> READ_MISS, signal2 NONE, stateOri 000, stateDest 001, cacheP1=001_10_0011, data 3, achei 0, inst 5 cycles after accept.
REQ-034 Then P2 read tag 2 -> HIT_SHARED, cacheP2=001_10_0011; then P1 write tag 2 data A -> INVALIDATE, INVAL_ACK, cacheP1=010_10_1010, cacheP2 state 000, memoria 3.
REQ-035 Then P3 read tag 2 -> READ_MISS, WRITEBACK, memoria A, cacheP1 state 001, cacheP3=001_10_1010, inst 6 cycles after accept.
REQ-036 Then P3 read tag 2 -> achei 1, signal NONE, data A, inst 3 cycles after accept.
REQ-037 P1 in M tag 2, P1 write tag 0 data 5 -> victim WB (memory[2] updated), WRITE_MISS, cacheP1=010_00_0101, inst 6 cycles after accept.
REQ-038 Reset asserted during BUS -> ready 1 next edge, no inst, caches/memory at reset values; id-0 request -> no inst, nothing changes.
